// File: rtl/memctrl_host_pkg.sv
// Shared types and constants for the memory-controller host adapter.
package memctrl_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RWAIT,
    ST_BIST_RUN,
    ST_BIST_DONE
  } state_e;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_RD_LAT       = 2;
  localparam int DEF_BIST_TIMEOUT = 200000;

  localparam logic PIN_CSB_IDLE = 1'b1;
  localparam logic PIN_CE_IDLE  = 1'b0;
  localparam logic PIN_WEB_IDLE = 1'b1;
  localparam logic PIN_OEB_IDLE = 1'b1;

endpackage

// File: rtl/memctrl_host_fifo.sv
// Synchronous command FIFO; head entry is visible on rdata whenever not empty.
module memctrl_host_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 25
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/memctrl_host_if.sv
// Host request adapter: queues byte read/write requests and sequences them,
// plus BIST handshakes, onto the memory controller pin interface.
//
// state      | meaning
// IDLE       | pins idle; start a pending BIST or pop the next request
// ISSUE      | one-cycle select with ADDR/IDATA/WEB from the popped entry
// RWAIT      | read select held with OEB low until ODATA is sampled
// BIST_RUN   | BIST_EN high until BIST_PASS or timeout
// BIST_DONE  | one cycle with BIST_EN low, then back to IDLE
module memctrl_host_if
  import memctrl_host_pkg::*;
#(
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int RD_LAT       = DEF_RD_LAT,
  parameter int BIST_TIMEOUT = DEF_BIST_TIMEOUT
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  input  logic        BIST_START,
  input  logic [2:0]  BIST_MODE_IN,
  output logic        BIST_BUSY,
  output logic        BIST_OK,
  output logic        BIST_FAIL,
  output logic [15:0] ADDR,
  output logic        CE,
  output logic        CSB,
  output logic        WEB,
  output logic        OEB,
  output logic [7:0]  IDATA,
  input  logic [7:0]  ODATA,
  output logic        BIST_EN,
  output logic [2:0]  BIST_MODE,
  input  logic        BIST_PASS
);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int TW = (BIST_TIMEOUT > 1) ? $clog2(BIST_TIMEOUT) : 1;

  state_e        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    idata_q, idata_d;
  logic          csb_q, csb_d, ce_q, ce_d, web_q, web_d, oeb_q, oeb_d;
  logic          bist_en_q, bist_en_d, bist_busy_q, bist_busy_d;
  logic          bist_ok_q, bist_ok_d, bist_fail_q, bist_fail_d;
  logic [2:0]    bist_mode_q, bist_mode_d, pend_mode_q, pend_mode_d;
  logic          pend_q, pend_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_rdata_q, rsp_rdata_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [TW-1:0] bist_cnt_q, bist_cnt_d;

  entry_t fifo_wdata, fifo_rdata;
  logic   fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign REQ_READY  = RSTN & ~fifo_full;
  assign fifo_push  = REQ_VALID & REQ_READY;
  assign fifo_wdata = {REQ_WE, REQ_ADDR, REQ_WDATA};

  memctrl_host_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idata_d     = idata_q;
    csb_d       = PIN_CSB_IDLE;
    ce_d        = PIN_CE_IDLE;
    web_d       = PIN_WEB_IDLE;
    oeb_d       = PIN_OEB_IDLE;
    bist_en_d   = 1'b0;
    bist_busy_d = 1'b0;
    bist_mode_d = '0;
    bist_ok_d   = bist_ok_q;
    bist_fail_d = bist_fail_q;
    pend_d      = pend_q;
    pend_mode_d = pend_mode_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    lat_cnt_d   = lat_cnt_q;
    bist_cnt_d  = bist_cnt_q;
    fifo_pop    = 1'b0;

    if (BIST_START && !pend_q && state_q != ST_BIST_RUN) begin
      pend_d      = 1'b1;
      pend_mode_d = BIST_MODE_IN;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d     = ST_BIST_RUN;
          pend_d      = 1'b0;
          bist_en_d   = 1'b1;
          bist_busy_d = 1'b1;
          bist_mode_d = pend_mode_q;
          bist_ok_d   = 1'b0;
          bist_fail_d = 1'b0;
          bist_cnt_d  = TW'(BIST_TIMEOUT - 1);
        end else if (!fifo_empty) begin
          state_d  = ST_ISSUE;
          fifo_pop = 1'b1;
          csb_d    = 1'b0;
          ce_d     = 1'b1;
          addr_d   = fifo_rdata.addr;
          idata_d  = fifo_rdata.wdata;
          web_d    = ~fifo_rdata.we;
          oeb_d    = fifo_rdata.we;
        end
      end
      // web_q still carries the issued entry's direction during ISSUE
      ST_ISSUE: begin
        if (web_q) begin
          state_d   = ST_RWAIT;
          csb_d     = 1'b0;
          oeb_d     = 1'b0;
          lat_cnt_d = LW'(RD_LAT - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RWAIT: begin
        if (lat_cnt_q == '0) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = ODATA;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
          csb_d     = 1'b0;
          oeb_d     = 1'b0;
        end
      end
      ST_BIST_RUN: begin
        if (BIST_PASS) begin
          state_d   = ST_BIST_DONE;
          bist_ok_d = 1'b1;
        end else if (bist_cnt_q == '0) begin
          state_d     = ST_BIST_DONE;
          bist_fail_d = 1'b1;
        end else begin
          bist_cnt_d  = bist_cnt_q - 1'b1;
          bist_en_d   = 1'b1;
          bist_busy_d = 1'b1;
          bist_mode_d = bist_mode_q;
        end
      end
      ST_BIST_DONE: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      idata_q     <= '0;
      csb_q       <= PIN_CSB_IDLE;
      ce_q        <= PIN_CE_IDLE;
      web_q       <= PIN_WEB_IDLE;
      oeb_q       <= PIN_OEB_IDLE;
      bist_en_q   <= 1'b0;
      bist_busy_q <= 1'b0;
      bist_mode_q <= '0;
      bist_ok_q   <= 1'b0;
      bist_fail_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_mode_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      lat_cnt_q   <= '0;
      bist_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      idata_q     <= idata_d;
      csb_q       <= csb_d;
      ce_q        <= ce_d;
      web_q       <= web_d;
      oeb_q       <= oeb_d;
      bist_en_q   <= bist_en_d;
      bist_busy_q <= bist_busy_d;
      bist_mode_q <= bist_mode_d;
      bist_ok_q   <= bist_ok_d;
      bist_fail_q <= bist_fail_d;
      pend_q      <= pend_d;
      pend_mode_q <= pend_mode_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      lat_cnt_q   <= lat_cnt_d;
      bist_cnt_q  <= bist_cnt_d;
    end
  end

  assign ADDR      = addr_q;
  assign IDATA     = idata_q;
  assign CSB       = csb_q;
  assign CE        = ce_q;
  assign WEB       = web_q;
  assign OEB       = oeb_q;
  assign BIST_EN   = bist_en_q;
  assign BIST_MODE = bist_mode_q;
  assign BIST_BUSY = bist_busy_q;
  assign BIST_OK   = bist_ok_q;
  assign BIST_FAIL = bist_fail_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;

endmodule

// File: tb/tb_memctrl_host_if.sv
// Directed bench for memctrl_host_if with a small pin-level memory/BIST model.
module tb_memctrl_host_if;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        bist_start = 1'b0;
  logic [2:0]  bist_mode_in = '0;
  logic        bist_busy, bist_ok, bist_fail;
  logic [15:0] addr;
  logic        ce, csb, web, oeb;
  logic [7:0]  idata, odata;
  logic        bist_en, bist_pass;
  logic [2:0]  bist_mode;

  logic        t_bist_start = 1'b0;
  logic [2:0]  t_bist_mode_in = '0;
  logic        t_req_ready, t_rsp_valid, t_bist_busy, t_bist_ok, t_bist_fail;
  logic [7:0]  t_rsp_rdata, t_idata;
  logic [15:0] t_addr;
  logic        t_ce, t_csb, t_web, t_oeb, t_bist_en;
  logic [2:0]  t_bist_mode;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  memctrl_host_if dut (
    .CLK(clk), .RSTN(rstn),
    .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WE(req_we),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
    .RSP_VALID(rsp_valid), .RSP_RDATA(rsp_rdata),
    .BIST_START(bist_start), .BIST_MODE_IN(bist_mode_in),
    .BIST_BUSY(bist_busy), .BIST_OK(bist_ok), .BIST_FAIL(bist_fail),
    .ADDR(addr), .CE(ce), .CSB(csb), .WEB(web), .OEB(oeb),
    .IDATA(idata), .ODATA(odata),
    .BIST_EN(bist_en), .BIST_MODE(bist_mode), .BIST_PASS(bist_pass)
  );

  memctrl_host_if #(.BIST_TIMEOUT(16)) dut_t (
    .CLK(clk), .RSTN(rstn),
    .REQ_VALID(1'b0), .REQ_READY(t_req_ready), .REQ_WE(1'b0),
    .REQ_ADDR(16'h0000), .REQ_WDATA(8'h00),
    .RSP_VALID(t_rsp_valid), .RSP_RDATA(t_rsp_rdata),
    .BIST_START(t_bist_start), .BIST_MODE_IN(t_bist_mode_in),
    .BIST_BUSY(t_bist_busy), .BIST_OK(t_bist_ok), .BIST_FAIL(t_bist_fail),
    .ADDR(t_addr), .CE(t_ce), .CSB(t_csb), .WEB(t_web), .OEB(t_oeb),
    .IDATA(t_idata), .ODATA(8'h00),
    .BIST_EN(t_bist_en), .BIST_MODE(t_bist_mode), .BIST_PASS(1'b0)
  );

  // Memory model: read data appears exactly two cycles after the issue cycle.
  logic [7:0]  mem [65536];
  logic [1:0]  rd_pipe = 2'b00;
  logic [15:0] rd_addr0 = '0, rd_addr1 = '0;
  int          cyc = 0, en_cnt = 0, en_len = 0, rsp_cnt = 0;
  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];
  logic        log_web[$];
  int          log_cyc[$];

  assign odata     = rd_pipe[1] ? mem[rd_addr1] : 8'hEE;
  assign bist_pass = bist_en && (en_cnt == 49);

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rd_pipe  <= {rd_pipe[0], (rstn && !csb && ce && web)};
    rd_addr0 <= addr;
    rd_addr1 <= rd_addr0;
    if (rstn && !csb && ce && !web) mem[addr] <= idata;
    if (rstn && !csb && ce) begin
      log_addr.push_back(addr);
      log_data.push_back(idata);
      log_web.push_back(web);
      log_cyc.push_back(cyc);
    end
    if (bist_en) en_cnt <= en_cnt + 1;
    else begin
      if (en_cnt != 0) en_len <= en_cnt;
      en_cnt <= 0;
    end
    if (rstn && rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_web.delete();
    log_cyc.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) tick();
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    checks++;
    if ({csb, ce, web, oeb, bist_en, rsp_valid, bist_busy, bist_ok, bist_fail} !== 9'b1_0_1_1_0_0_0_0_0) begin
      failures++;
      $display("FAIL reset_ctl got=%b exp=101100000", {csb, ce, web, oeb, bist_en, rsp_valid, bist_busy, bist_ok, bist_fail});
    end
    checks++;
    if ({addr, idata, rsp_rdata, bist_mode} !== 35'd0) begin
      failures++;
      $display("FAIL reset_data got addr=%h idata=%h rdata=%h mode=%h exp=0", addr, idata, rsp_rdata, bist_mode);
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b exp=1", req_ready); end
    tick();
  endtask

  task automatic test_write();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h1234; req_wdata = 8'hA5;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL wr_ready got=%b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++;
    if (csb !== 1'b1) begin failures++; $display("FAIL wr_early got csb=%b exp=1", csb); end
    tick();
    checks++;
    if ({csb, ce, web, oeb} !== 4'b0101) begin failures++; $display("FAIL wr_pins got=%b exp=0101", {csb, ce, web, oeb}); end
    checks++;
    if (addr !== 16'h1234 || idata !== 8'hA5) begin
      failures++; $display("FAIL wr_addr_data got=%h/%h exp=1234/a5", addr, idata);
    end
    tick();
    checks++;
    if ({csb, ce} !== 2'b10) begin failures++; $display("FAIL wr_one_cycle got=%b exp=10", {csb, ce}); end
  endtask

  task automatic test_read();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234; req_wdata = 8'h00;
    tick();
    req_valid = 1'b0;
    tick();
    checks++;
    if ({csb, ce, web, oeb} !== 4'b0110 || addr !== 16'h1234) begin
      failures++; $display("FAIL rd_issue got pins=%b addr=%h exp=0110/1234", {csb, ce, web, oeb}, addr);
    end
    tick();
    checks++;
    if ({csb, ce, web, oeb} !== 4'b0010 || addr !== 16'h1234) begin
      failures++; $display("FAIL rd_wait_pins got pins=%b addr=%h exp=0010/1234", {csb, ce, web, oeb}, addr);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd_early_rsp got=%b exp=0", rsp_valid); end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      failures++; $display("FAIL rd_rsp got valid=%b data=%h exp=1/a5", rsp_valid, rsp_rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 8'hA5) begin
      failures++; $display("FAIL rd_hold got valid=%b data=%h exp=0/a5", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    clear_log();
    bist_start = 1'b1; bist_mode_in = 3'b001;
    tick();
    bist_start = 1'b0;
    n = 0;
    while (bist_busy !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (n >= 10) begin failures++; $display("FAIL b2b_bist_start got busy=%b exp=1", bist_busy); end
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0100 + 16'(i); req_wdata = 8'h10 + 8'(i);
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", i, req_ready); end
      tick();
    end
    req_addr = 16'h0104; req_wdata = 8'h14;
    checks++;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got ready=%b exp=0", req_ready); end
    n = 0;
    while (req_ready !== 1'b1 && n < 300) begin tick(); n++; end
    checks++;
    if (n >= 300) begin failures++; $display("FAIL b2b_ready_return got ready=%b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    n = 0;
    while (log_addr.size() < 5 && n < 100) begin tick(); n++; end
    checks++;
    if (log_addr.size() != 5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", log_addr.size()); end
    for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
      checks++;
      if (log_addr[i] !== 16'h0100 + 16'(i) || log_data[i] !== 8'h10 + 8'(i) || log_web[i] !== 1'b0) begin
        failures++;
        $display("FAIL b2b_entry%0d got addr=%h data=%h web=%b exp=%h/%h/0", i, log_addr[i], log_data[i], log_web[i], 16'h0100 + 16'(i), 8'h10 + 8'(i));
      end
      if (i > 0) begin
        checks++;
        if (log_cyc[i] - log_cyc[i-1] != 2) begin
          failures++; $display("FAIL b2b_spacing%0d got=%0d exp=2", i, log_cyc[i] - log_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_bist();
    int n;
    logic saw_en;
    clear_log();
    bist_start = 1'b1; bist_mode_in = 3'b101;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234; req_wdata = 8'h00;
    tick();
    bist_start = 1'b0; req_valid = 1'b0;
    checks++;
    if (bist_en !== 1'b0) begin failures++; $display("FAIL bist_en_early got=%b exp=0", bist_en); end
    tick();
    checks++;
    if ({bist_en, bist_busy, bist_ok, bist_fail, csb} !== 5'b11001 || bist_mode !== 3'd5) begin
      failures++;
      $display("FAIL bist_run got en/busy/ok/fail/csb=%b mode=%0d exp=11001/5", {bist_en, bist_busy, bist_ok, bist_fail, csb}, bist_mode);
    end
    bist_start = 1'b1; bist_mode_in = 3'b010;
    tick();
    bist_start = 1'b0;
    n = 0;
    while (bist_en === 1'b1 && n < 200) begin tick(); n++; end
    checks++;
    if ({bist_busy, bist_ok, bist_fail} !== 3'b010) begin
      failures++; $display("FAIL bist_done got busy/ok/fail=%b exp=010", {bist_busy, bist_ok, bist_fail});
    end
    saw_en = 1'b0;
    repeat (3) begin tick(); saw_en = saw_en | bist_en; end
    checks++;
    if (en_len != 50) begin failures++; $display("FAIL bist_en_len got=%0d exp=50", en_len); end
    checks++;
    if (saw_en !== 1'b0) begin failures++; $display("FAIL bist_restart got en=%b exp=0", saw_en); end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin
      failures++; $display("FAIL bist_queued_read got valid=%b data=%h exp=1/a5", rsp_valid, rsp_rdata);
    end
    checks++;
    if (log_addr.size() < 1 || log_addr[0] !== 16'h1234 || log_web[0] !== 1'b1) begin
      failures++; $display("FAIL bist_queued_issue got n=%0d exp=read of 1234", log_addr.size());
    end
  endtask

  task automatic test_timeout();
    int n;
    t_bist_start = 1'b1; t_bist_mode_in = 3'b011;
    tick();
    t_bist_start = 1'b0;
    tick();
    checks++;
    if (t_bist_en !== 1'b1 || t_bist_mode !== 3'd3) begin
      failures++; $display("FAIL to_start got en=%b mode=%0d exp=1/3", t_bist_en, t_bist_mode);
    end
    n = 0;
    while (t_bist_en === 1'b1 && n < 100) begin n++; tick(); end
    checks++;
    if (n != 16) begin failures++; $display("FAIL to_len got=%0d exp=16", n); end
    checks++;
    if ({t_bist_en, t_bist_busy, t_bist_ok, t_bist_fail} !== 4'b0001) begin
      failures++; $display("FAIL to_flags got en/busy/ok/fail=%b exp=0001", {t_bist_en, t_bist_busy, t_bist_ok, t_bist_fail});
    end
  endtask

  task automatic test_reset_mid_read();
    int rsp0;
    rsp0 = rsp_cnt;
    clear_log();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h1234; req_wdata = 8'h00;
    tick();
    req_we = 1'b1; req_addr = 16'h2222; req_wdata = 8'h33;
    tick();
    req_valid = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    checks++;
    if ({csb, ce, web, oeb, req_ready} !== 5'b10110) begin
      failures++; $display("FAIL rst_mid_pins got csb/ce/web/oeb/ready=%b exp=10110", {csb, ce, web, oeb, req_ready});
    end
    repeat (2) tick();
    rstn = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
    repeat (8) tick();
    checks++;
    if (rsp_cnt != rsp0) begin failures++; $display("FAIL rst_mid_rsp got=%0d exp=%0d", rsp_cnt, rsp0); end
    checks++;
    if (log_addr.size() != 1) begin failures++; $display("FAIL rst_mid_fifo got issues=%0d exp=1", log_addr.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_bist();
    test_timeout();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got cycles=%0d exp=bench completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
